// File: rtl/kb_key_fifo.sv
// kb_key_fifo: filters PS/2 make codes and buffers their ASCII bytes
// in a first-word-fall-through FIFO drained by a valid/pop reader.
module kb_key_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    scan_code,
    input  logic          scan_code_ready,
    input  logic [7:0]    ascii_code,
    input  logic          pop,
    input  logic          clear_overflow,
    output logic          key_valid,
    output logic [7:0]    key_data,
    output logic [AW:0]   key_count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic cand;
    logic push;
    logic pop_eff;
    logic full;
    logic wr_en;

    // Prefix filter: only plain make codes seen in IDLE become candidates
    always_comb begin
        state_d = state_q;
        cand    = 1'b0;
        if (scan_code_ready) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_code == CODE_BRK) begin
                        state_d = BREAK;
                    end else if (scan_code == CODE_EXT) begin
                        state_d = EXT;
                    end else begin
                        cand = 1'b1;
                    end
                end
                BREAK:     state_d = IDLE;
                EXT: begin
                    if (scan_code == CODE_BRK) begin
                        state_d = EXT_BREAK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EXT_BREAK: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when a pop frees a slot
    always_comb begin
        push     = cand && (ascii_code != 8'h00);
        full     = (count_q == FULL_CNT);
        pop_eff  = pop && (count_q != '0);
        wr_en    = push && (!full || pop_eff);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (wr_en && !pop_eff) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_en && pop_eff) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (push && full && !pop_eff) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= ascii_code;
        end
    end

    assign key_valid = (count_q != '0);
    assign key_data  = mem_q[rd_ptr_q];
    assign key_count = count_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/kb_key_fifo.md
# kb_key_fifo

Keystroke buffer that sits directly downstream of the PS/2 keyboard front end. It consumes raw scan-code pulses and their combinationally translated ASCII codes, and discards break (key-release), extended-prefix and unmapped codes. Each remaining key press is stored as one ASCII byte in a first-word-fall-through FIFO. The CPU-side reader drains the FIFO through a valid/pop handshake, so keystrokes arriving between CPU polls are not lost.

## Interface
Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  system clock; sole clock of the block.
- reset  input  1  synchronous, active-high reset.
- scan_code  input  8  PS/2 scan code byte from the receiver.
- scan_code_ready  input  1  one-cycle strobe; scan_code is valid in that cycle.
- ascii_code  input  8  ASCII translation of scan_code (already case-resolved); 0x00 means unmapped.
- pop  input  1  reader consumes the head entry this cycle.
- clear_overflow  input  1  clears the sticky overflow flag.
- key_valid  output  1  FIFO non-empty; key_data is valid.
- key_data  output  8  head-of-FIFO ASCII byte.
- key_count  output  AW+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky; set when a key was dropped because the FIFO was full.

## Operation
- Filter FSM, states IDLE, BREAK, EXT, EXT_BREAK. Transitions evaluate only in cycles where scan_code_ready=1; the FSM holds state otherwise.
  - IDLE: code 0xF0 -> BREAK; code 0xE0 -> EXT; any other code -> candidate push, stay in IDLE.
  - BREAK: any code -> IDLE, no push. This drops the released key.
  - EXT: code 0xF0 -> EXT_BREAK; any other code -> IDLE, no push. Extended keys are not buffered.
  - EXT_BREAK: any code -> IDLE, no push.
- Push condition: a candidate push in IDLE with ascii_code != 0x00. Modifier keys such as shift (0x12/0x59) map to 0x00 and are therefore never stored.
- FIFO: circular buffer of DEPTH bytes with AW-bit read and write pointers that wrap modulo DEPTH. Full and empty are derived from key_count.
- Pop is effective only when key_valid=1. A pop while empty is ignored and changes no state.
- Push while full with no effective pop in the same cycle: the byte is dropped, overflow is set to 1, and pointers and count are unchanged.
- Simultaneous push and effective pop:
  - Full: both are accepted and key_count stays at DEPTH; no overflow.
  - Empty: the pop is ineffective and only the push occurs.
  - Otherwise: both occur and key_count is unchanged.
- overflow precedence: a set in the same cycle as clear_overflow wins, so overflow stays 1.
- key_data = mem[rd_ptr] (first-word-fall-through). key_data is undefined while key_valid=0, and the bench must not check it then.

## Timing
- Reset (synchronous, at the clock edge with reset=1) sets: FSM to IDLE, both pointers to 0, key_count=0, key_valid=0, overflow=0. key_data is not reset and has no reset value; it is don't-care while key_valid=0.
- Reset asserted mid-sequence (e.g. after 0xF0) discards the pending FSM state and all stored entries.
- Push latency: a strobe sampled at edge N updates the entry and key_count at edge N. key_valid and key_data are visible in the cycle after edge N, so there is one cycle from strobe to visibility.
- Pop: pop sampled at edge N advances the head at edge N; the next entry (or key_valid=0) is visible after edge N.
- key_count, key_valid and overflow are registered or derived directly from registers, with no combinational path from the inputs.
- Back-to-back strobes on consecutive cycles are supported, and each is filtered independently.

## Test plan
- Make/break filtering: scan 0x1C (ascii 0x61), then 0xF0, then 0x1C -> exactly one entry; key_data=0x61 and key_count=1. After one pop: key_valid=0 and key_count=0.
- Extended and modifier keys: sequence E0 75 E0 F0 75, then 12 (ascii 0x00), then F0 12 -> key_count stays 0 and overflow=0 throughout.
- Ordering and overflow with DEPTH=16: push 17 distinct keys (ascii 0x41..0x51) with no pops -> key_count=16 and overflow=1. Popping 16 times yields 0x41..0x50 in order, then key_valid=0. Pulsing clear_overflow -> overflow=0.
- Full plus simultaneous push/pop: with the FIFO full, strobe key 0x7A while pop=1 -> key_count stays 16, overflow stays 0, and the new head is the former second entry. 0x7A is read last.
- Pointer wrap: 40 single push/pop pairs -> each popped byte equals the byte pushed, and key_count never exceeds 1.
- Reset mid-operation: 3 entries stored and FSM in BREAK; assert reset for one cycle -> key_count=0, key_valid=0, overflow=0. A following scan 0x1C (ascii 0x61) is stored rather than swallowed.
